// File: rtl/mips_lsu_pkg.sv
// Shared types and op-class helpers for the MIPS load/store unit.
package mips_lsu_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10
  } mem_op_t;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t S_IDLE   = 2'd0;
  localparam lsu_state_t S_ACCESS = 2'd1;
  localparam lsu_state_t S_RESP   = 2'd2;
  localparam lsu_state_t S_ERR    = 2'd3;

  function automatic logic is_load(logic [3:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU,
                      OP_LW, OP_LWL, OP_LWR};
  endfunction

  function automatic logic is_store(logic [3:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_half(logic [3:0] op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction

  function automatic logic is_word(logic [3:0] op);
    return op inside {OP_LW, OP_SW};
  endfunction

  function automatic logic misaligned(logic [3:0] op,
                                      logic [1:0] o);
    return (is_half(op) && o[0]) ||
           (is_word(op) && (o != 2'b00));
  endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Byte-lane steering for stores and load result formatting,
// including the LWL/LWR merge with the old rt value.
module mips_lsu_align
  import mips_lsu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  o_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] rt_old_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic [31:0] load_o
);

  logic [4:0]  shr;
  logic [4:0]  shl;
  logic [31:0] rsh;
  logic [7:0]  b;
  logic [15:0] h;

  assign shr = {o_i, 3'b000};
  assign shl = {~o_i, 3'b000};
  assign rsh = rdata_i >> shr;
  assign b   = rsh[7:0];
  assign h   = o_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o   = 4'b0000;
    wd_o   = 32'h0;
    load_o = 32'h0;
    case (op_i)
      OP_SB: begin
        be_o = 4'b0001 << o_i;
        wd_o = {4{wdata_i[7:0]}};
      end
      OP_SH: begin
        be_o = 4'b0011 << o_i;
        wd_o = {2{wdata_i[15:0]}};
      end
      OP_SW: begin
        be_o = 4'b1111;
        wd_o = wdata_i;
      end
      OP_LB: begin
        be_o   = 4'b1111;
        load_o = {{24{b[7]}}, b};
      end
      OP_LBU: begin
        be_o   = 4'b1111;
        load_o = {24'h0, b};
      end
      OP_LH: begin
        be_o   = 4'b1111;
        load_o = {{16{h[15]}}, h};
      end
      OP_LHU: begin
        be_o   = 4'b1111;
        load_o = {16'h0, h};
      end
      OP_LW: begin
        be_o   = 4'b1111;
        load_o = rdata_i;
      end
      // Shift amounts never reach 32 here, so no wrap guard needed
      OP_LWL: begin
        be_o   = 4'b1111;
        load_o = (rdata_i << shl) |
                 (rt_old_i & ((32'h1 << shl) - 32'h1));
      end
      OP_LWR: begin
        be_o   = 4'b1111;
        load_o = rsh |
                 (rt_old_i & ~(32'hffff_ffff >> shr));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: Avalon-MM master FSM with wait timeout,
// alignment trap and registered load result.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] load_result,
  output logic        align_err,
  output logic        bus_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  localparam int CW =
    (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam int TO_LAST_I =
    (WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];
  localparam bit TO_EN = (WAIT_TIMEOUT > 0);

  lsu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        berr_q, berr_d;
  logic [3:0]  op_q;
  logic [1:0]  o_q;
  logic [31:0] wdata_q;
  logic [31:0] rt_q;
  logic [31:0] addr_q;
  logic [31:0] ld_q;

  logic [3:0]  be_w;
  logic [31:0] wd_w;
  logic [31:0] ld_w;
  logic        in_acc;
  logic        accept;

  mips_lsu_align u_align (
    .op_i     (op_q),
    .o_i      (o_q),
    .wdata_i  (wdata_q),
    .rdata_i  (avm_readdata),
    .rt_old_i (rt_q),
    .be_o     (be_w),
    .wd_o     (wd_w),
    .load_o   (ld_w)
  );

  assign in_acc = (state_q == S_ACCESS);
  assign accept = (state_q == S_IDLE) && req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    berr_d  = berr_q;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall = req_valid;
        cnt_d = '0;
        if (req_valid) begin
          if (!is_load(req_op) && !is_store(req_op)) begin
            state_d = S_RESP;
          end else if (misaligned(req_op, req_addr[1:0])) begin
            state_d = S_ERR;
            berr_d  = 1'b0;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        stall = 1'b1;
        if (!avm_waitrequest) begin
          state_d = S_RESP;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          state_d = S_ERR;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 4'h0;
      o_q     <= 2'b00;
      wdata_q <= 32'h0;
      rt_q    <= 32'h0;
      addr_q  <= 32'h0;
      ld_q    <= 32'h0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        o_q     <= req_addr[1:0];
        wdata_q <= req_wdata;
        rt_q    <= req_rt_old;
        addr_q  <= {req_addr[31:2], 2'b00};
      end
      if (in_acc && !avm_waitrequest) begin
        ld_q <= ld_w;
      end
    end
  end

  assign rsp_valid      = (state_q == S_RESP);
  assign align_err      = (state_q == S_ERR) && !berr_q;
  assign bus_err        = (state_q == S_ERR) && berr_q;
  assign load_result    = ld_q;
  assign avm_address    = addr_q;
  assign avm_read       = in_acc && is_load(op_q);
  assign avm_write      = in_acc && is_store(op_q);
  assign avm_byteenable = in_acc ? be_w : 4'b0000;
  assign avm_writedata  = in_acc ? wd_w : 32'h0;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed plus random stimulus for mips_lsu against a
// byte-level reference model of MIPS load/store semantics.
module tb_mips_lsu;
  import mips_lsu_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_rt_old = 32'h0;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] load_result;
  logic        align_err;
  logic        bus_err;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mips_lsu #(.WAIT_TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_rt_old      (req_rt_old),
    .stall           (stall),
    .rsp_valid       (rsp_valid),
    .load_result     (load_result),
    .align_err       (align_err),
    .bus_err         (bus_err),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Reference: build the result byte by byte from memory
  // bytes and old-rt bytes, as the ISA describes it.
  function automatic logic [31:0] exp_load(
      input logic [3:0] op, input logic [1:0] o,
      input logic [31:0] m, input logic [31:0] rt);
    logic [7:0] mb [4];
    logic [7:0] rb [4];
    logic [7:0] res [4];
    logic signed [31:0] s;
    int hi;
    for (int k = 0; k < 4; k++) begin
      mb[k] = m[8*k +: 8];
      rb[k] = rt[8*k +: 8];
      res[k] = rb[k];
    end
    hi = o[1] ? 2 : 0;
    case (op)
      OP_LB: begin
        s = $signed(mb[o]);
        return s;
      end
      OP_LBU: return {24'h0, mb[o]};
      OP_LH: begin
        s = $signed({mb[hi+1], mb[hi]});
        return s;
      end
      OP_LHU: return {16'h0, mb[hi+1], mb[hi]};
      OP_LW: return m;
      OP_LWL: begin
        for (int k = 0; k < 4; k++)
          if (k >= 3 - int'(o)) res[k] = mb[k - (3 - int'(o))];
        return {res[3], res[2], res[1], res[0]};
      end
      OP_LWR: begin
        for (int k = 0; k < 4; k++)
          if (k <= 3 - int'(o)) res[k] = mb[k + int'(o)];
        return {res[3], res[2], res[1], res[0]};
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [31:0] rt,
                        input logic [31:0] m,
                        input int nwait);
    logic [1:0]  o;
    bit          ld, st, bad;
    int          acc;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    o  = addr[1:0];
    ld = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU,
                    OP_LW, OP_LWL, OP_LWR};
    st = op inside {OP_SB, OP_SH, OP_SW};
    bad = ((op == OP_LH || op == OP_LHU || op == OP_SH)
           && o[0]) ||
          ((op == OP_LW || op == OP_SW) && o != 2'd0);
    ebe = (op == OP_SB) ? 4'b0001 << o :
          (op == OP_SH) ? 4'b0011 << o : 4'b1111;
    ewd = (op == OP_SB) ? {4{wd[7:0]}} :
          (op == OP_SH) ? {2{wd[15:0]}} : wd;

    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    req_wdata = wd; req_rt_old = rt; avm_readdata = m;
    #1 chk("idle_stall", stall, 1);
    @(negedge clk);
    if (!ld && !st) begin
      chk("noop_rsp", rsp_valid, 1);
      chk("noop_rd", avm_read, 0);
      chk("noop_wr", avm_write, 0);
    end else if (bad) begin
      chk("align_err", align_err, 1);
      chk("align_stall", stall, 0);
      chk("align_rd", avm_read, 0);
      chk("align_wr", avm_write, 0);
      chk("align_rsp", rsp_valid, 0);
    end else begin
      acc = (nwait >= TO) ? TO : nwait + 1;
      for (int i = 0; i < acc; i++) begin
        if (i > 0) @(negedge clk);
        chk("acc_rd", avm_read, ld);
        chk("acc_wr", avm_write, st);
        chk("acc_addr", avm_address, {addr[31:2], 2'b00});
        chk("acc_be", avm_byteenable, ebe);
        if (st) chk("acc_wd", avm_writedata, ewd);
        chk("acc_stall", stall, 1);
        chk("acc_rsp", rsp_valid, 0);
        avm_waitrequest = (i < nwait);
      end
      @(negedge clk);
      if (nwait >= TO) begin
        chk("to_buserr", bus_err, 1);
        chk("to_rsp", rsp_valid, 0);
        chk("to_rd", avm_read, 0);
        chk("to_wr", avm_write, 0);
      end else begin
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_stall", stall, 0);
        chk("rsp_rd", avm_read, 0);
        chk("rsp_wr", avm_write, 0);
        chk("rsp_buserr", bus_err, 0);
        if (ld)
          chk("load_result", load_result,
              exp_load(op, o, m, rt));
      end
    end
    req_valid = 1'b0;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    chk("idle_rsp", rsp_valid, 0);
    chk("idle_aerr", align_err, 0);
    chk("idle_berr", bus_err, 0);
    chk("idle_stall0", stall, 0);
  endtask

  initial begin
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_aerr", align_err, 0);
    chk("rst_berr", bus_err, 0);
    chk("rst_rd", avm_read, 0);
    chk("rst_wr", avm_write, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_wd", avm_writedata, 0);
    chk("rst_be", avm_byteenable, 0);
    chk("rst_ld", load_result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(OP_LB,  32'h1003, 0, 0, 32'h80FF_1234, 0);
    run_op(OP_SH,  32'h2002, 32'h0000_BEEF, 0, 0, 3);
    run_op(OP_LWL, 32'h01, 0, 32'h1122_3344,
           32'hAABB_CCDD, 0);
    run_op(OP_LWR, 32'h01, 0, 32'h1122_3344,
           32'hAABB_CCDD, 1);
    run_op(OP_LW,  32'h3002, 0, 0, 32'h1234_5678, 0);
    run_op(OP_LW,  32'h5000, 0, 0, 0, TO);
    run_op(OP_SW,  32'h6004, 32'hCAFE_F00D, 0, 0, TO - 1);
    run_op(4'd7,   32'h7000, 0, 0, 0, 0);

    // Reset while a read is stuck in ACCESS
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LW;
    req_addr = 32'h4000; avm_waitrequest = 1'b1;
    @(negedge clk);
    chk("pre_rst_rd", avm_read, 1);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rd", avm_read, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    @(negedge clk);
    avm_waitrequest = 1'b0;
    rst_n = 1'b1;
    chk("post_rst_rsp", rsp_valid, 0);
    run_op(OP_LHU, 32'h0002, 0, 0, 32'h8001_0000, 0);

    for (int n = 0; n < 60; n++) begin
      run_op(4'($urandom_range(0, 15)), $urandom,
             $urandom, $urandom, $urandom,
             $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
